// File: rtl/sram_flow_stats_rmw.sv
// sram_flow_stats_rmw: per-flow packet/byte counter read-modify-write engine over QDR SRAM
module sram_flow_stats_rmw #(
    parameter int ADDR_WIDTH     = 11,
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int MEM_DATA_WIDTH = 216,
    parameter int PKT_CNT_WIDTH  = 32,
    parameter int BYTE_CNT_WIDTH = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int DEPTH          = 16,
    parameter int SATURATE       = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cal_done,
    input  logic                      init_start,
    output logic                      init_done,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [ADDR_WIDTH-1:0]     upd_addr,
    input  logic [LEN_WIDTH-1:0]      upd_len,
    output logic                      rd_req,
    output logic [MEM_ADDR_WIDTH-1:0] rd_addr,
    input  logic                      rd_full,
    input  logic [MEM_DATA_WIDTH-1:0] rd_data,
    input  logic                      rd_data_valid,
    output logic                      wr_req,
    output logic [MEM_ADDR_WIDTH-1:0] wr_addr,
    output logic [MEM_DATA_WIDTH-1:0] wr_data,
    input  logic                      wr_full,
    output logic                      err_unexpected
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int PC = PKT_CNT_WIDTH;
    localparam int BC = BYTE_CNT_WIDTH;

    typedef enum logic [1:0] {IDLE, INIT, RUN, DRAIN} state_t;
    state_t state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [ADDR_WIDTH-1:0] pend_addr [DEPTH];
    logic [LEN_WIDTH-1:0] pend_len [DEPTH];
    logic [PW-1:0] pend_wp, pend_rp;
    logic [CW-1:0] pend_cnt;
    logic [ADDR_WIDTH-1:0] wb_addr [DEPTH];
    logic [MEM_DATA_WIDTH-1:0] wb_data [DEPTH];
    logic [PW-1:0] wb_wp, wb_rp;
    logic [CW-1:0] wb_cnt;
    logic [CW:0] occ;
    logic hazard, accept, resp, wb_pop;
    logic [PC:0] pkt_sum;
    logic [BC:0] byte_sum;
    logic [MEM_DATA_WIDTH-1:0] new_word;

    // an entry is live when its distance from the read pointer is below the count
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PW'(PW'(i) - pend_rp)} < pend_cnt && pend_addr[i] == upd_addr) hazard = 1'b1;
            if ({1'b0, PW'(PW'(i) - wb_rp)} < wb_cnt && wb_addr[i] == upd_addr) hazard = 1'b1;
        end
    end

    always_comb begin
        pkt_sum = {1'b0, rd_data[PC-1:0]} + (PC+1)'(1);
        byte_sum = {1'b0, rd_data[PC+BC-1:PC]} + (BC+1)'(pend_len[pend_rp]);
        new_word = rd_data;
        new_word[PC-1:0] = (SATURATE != 0 && pkt_sum[PC]) ? '1 : pkt_sum[PC-1:0];
        new_word[PC+BC-1:PC] = (SATURATE != 0 && byte_sum[BC]) ? '1 : byte_sum[BC-1:0];
    end

    assign occ = {1'b0, pend_cnt} + {1'b0, wb_cnt};
    assign upd_ready = state == RUN && !rd_full && occ < (CW+1)'(DEPTH) && !hazard;
    assign accept = upd_valid && upd_ready;
    assign resp = rd_data_valid && pend_cnt != '0;
    assign wb_pop = wb_cnt != '0 && !wr_full;
    assign init_done = state == RUN;
    assign wr_req = state == INIT ? !wr_full : wb_pop;
    assign wr_addr = state == INIT ? MEM_ADDR_WIDTH'(init_cnt) :
                     wb_cnt != '0 ? MEM_ADDR_WIDTH'(wb_addr[wb_rp]) : '0;
    assign wr_data = (state != INIT && wb_cnt != '0) ? wb_data[wb_rp] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            init_cnt <= '0;
            pend_wp <= '0;
            pend_rp <= '0;
            pend_cnt <= '0;
            wb_wp <= '0;
            wb_rp <= '0;
            wb_cnt <= '0;
            rd_req <= 1'b0;
            rd_addr <= '0;
            err_unexpected <= 1'b0;
        end else begin
            rd_req <= accept;
            if (accept) begin
                rd_addr <= MEM_ADDR_WIDTH'(upd_addr);
                pend_addr[pend_wp] <= upd_addr;
                pend_len[pend_wp] <= upd_len;
                pend_wp <= pend_wp + PW'(1);
            end
            if (resp) begin
                pend_rp <= pend_rp + PW'(1);
                wb_addr[wb_wp] <= pend_addr[pend_rp];
                wb_data[wb_wp] <= new_word;
                wb_wp <= wb_wp + PW'(1);
            end
            if (wb_pop) wb_rp <= wb_rp + PW'(1);
            pend_cnt <= pend_cnt + CW'(accept) - CW'(resp);
            wb_cnt <= wb_cnt + CW'(resp) - CW'(wb_pop);
            if (rd_data_valid && pend_cnt == '0) err_unexpected <= 1'b1;
            case (state)
                IDLE: if (cal_done) begin
                    state <= INIT;
                    init_cnt <= '0;
                end
                INIT: if (!wr_full) begin
                    init_cnt <= init_cnt + ADDR_WIDTH'(1);
                    if (&init_cnt) state <= RUN;
                end
                RUN: if (init_start) state <= DRAIN;
                DRAIN: if (pend_cnt == '0 && wb_cnt == '0) begin
                    state <= INIT;
                    init_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_flow_stats_rmw.sv
// tb_sram_flow_stats_rmw: directed checks of the counter RMW engine against a 2-cycle SRAM model
module tb_sram_flow_stats_rmw;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cal_done = 1'b0;
    logic init_start = 1'b0;
    logic upd_valid = 1'b0;
    logic rd_full = 1'b0;
    logic wr_full = 1'b0;
    logic inj = 1'b0;
    logic pre_v = 1'b0;
    logic [3:0] upd_addr = '0;
    logic [3:0] pre_addr = '0;
    logic [15:0] upd_len = '0;
    logic [71:0] pre_data = '0;
    logic init_done, upd_ready, rd_req, wr_req, err_unexpected, rd_data_valid;
    logic [7:0] rd_addr, wr_addr;
    logic [71:0] wr_data, rd_data;
    logic init_done_s0, upd_ready_s0, rd_req_s0, wr_req_s0, err_s0;
    logic [7:0] rd_addr_s0, wr_addr_s0;
    logic [71:0] wr_data_s0;
    logic [71:0] mem [16];
    logic v1, v2;
    logic [7:0] a1, a2;
    logic [7:0] wa [$];
    logic [71:0] wd [$];
    logic [71:0] wd0 [$];
    int wc [$];
    int ac [$];
    int cyc = 0;
    int done_cyc = -1;
    bit rdy_done;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_flow_stats_rmw #(.ADDR_WIDTH(4), .MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(72), .PKT_CNT_WIDTH(32),
        .BYTE_CNT_WIDTH(32), .LEN_WIDTH(16), .DEPTH(4), .SATURATE(1)) dut (
        .clk(clk), .reset(reset), .cal_done(cal_done), .init_start(init_start), .init_done(init_done),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_len(upd_len),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_full(rd_full), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_full(wr_full), .err_unexpected(err_unexpected));

    sram_flow_stats_rmw #(.ADDR_WIDTH(4), .MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(72), .PKT_CNT_WIDTH(32),
        .BYTE_CNT_WIDTH(32), .LEN_WIDTH(16), .DEPTH(4), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .cal_done(cal_done), .init_start(init_start), .init_done(init_done_s0),
        .upd_valid(upd_valid), .upd_ready(upd_ready_s0), .upd_addr(upd_addr), .upd_len(upd_len),
        .rd_req(rd_req_s0), .rd_addr(rd_addr_s0), .rd_full(rd_full), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .wr_req(wr_req_s0), .wr_addr(wr_addr_s0), .wr_data(wr_data_s0),
        .wr_full(wr_full), .err_unexpected(err_s0));

    assign rd_data_valid = v2 | inj;
    assign rd_data = mem[a2[3:0]];

    always @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= rd_req;
            v2 <= v1;
        end
        a1 <= rd_addr;
        a2 <= a1;
        if (wr_req) mem[wr_addr[3:0]] <= wr_data;
        else if (pre_v) mem[pre_addr] <= pre_data;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
        if (wr_req) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            wd0.push_back(wr_data_s0);
            wc.push_back(cyc);
        end
        if (upd_valid && upd_ready) ac.push_back(cyc);
        if (init_done && done_cyc < 0) begin
            done_cyc = cyc;
            rdy_done = upd_ready;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear();
        wa.delete();
        wd.delete();
        wd0.delete();
        wc.delete();
        ac.delete();
        done_cyc = -1;
    endtask

    task automatic offer(input logic [3:0] a, input logic [15:0] l, output bit ok);
        int n;
        n = ac.size();
        upd_addr = a;
        upd_len = l;
        upd_valid = 1'b1;
        for (int i = 0; i < 30 && ac.size() == n; i++) step();
        upd_valid = 1'b0;
        ok = ac.size() != n;
    endtask

    task automatic preload(input logic [3:0] a, input logic [71:0] d);
        pre_addr = a;
        pre_data = d;
        pre_v = 1'b1;
        step();
        pre_v = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({rd_req, wr_req, init_done, upd_ready, err_unexpected} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {rd_req, wr_req, init_done, upd_ready, err_unexpected});
        end
        checks++;
        if ({rd_addr, wr_addr} !== 16'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 0000", {rd_addr, wr_addr});
        end
        checks++;
        if (wr_data !== 72'h0) begin
            errors++;
            $display("FAIL reset_wr_data: got %h expected 0", wr_data);
        end
    endtask

    task automatic test_init();
        clear();
        reset = 1'b0;
        cal_done = 1'b1;
        for (int i = 0; i < 40 && done_cyc < 0; i++) step();
        checks++;
        if (wa.size() != 16) begin
            errors++;
            $display("FAIL init_count: got %0d writes expected 16", wa.size());
        end
        for (int j = 0; j < wa.size(); j++) begin
            checks++;
            if (wa[j] !== 8'(j) || wd[j] !== 72'h0) begin
                errors++;
                $display("FAIL init_write%0d: got addr %0d data %h expected addr %0d data 0", j, wa[j], wd[j], j);
            end
        end
        checks++;
        if (wc.size() != 16 || wc[15] - wc[0] != 15) begin
            errors++;
            $display("FAIL init_consecutive: got span %0d expected 15", wc.size() == 16 ? wc[15] - wc[0] : -1);
        end
        checks++;
        if (wc.size() != 16 || done_cyc != wc[15] + 1) begin
            errors++;
            $display("FAIL init_done_timing: got cycle %0d expected one after last write", done_cyc);
        end
        checks++;
        if (rdy_done !== 1'b1) begin
            errors++;
            $display("FAIL init_upd_ready: got %b expected 1", rdy_done);
        end
    endtask

    task automatic test_basic();
        bit ok;
        preload(4'd5, {8'hA5, 32'd100, 32'd3});
        clear();
        offer(4'd5, 16'd64, ok);
        repeat (10) step();
        checks++;
        if (!ok || wa.size() != 1) begin
            errors++;
            $display("FAIL basic_count: got accepted %0d writes %0d expected 1 write", ok, wa.size());
        end
        checks++;
        if (wa.size() != 1 || wa[0] !== 8'd5 || wd[0] !== {8'hA5, 32'd164, 32'd4}) begin
            errors++;
            $display("FAIL basic_write: got %h expected addr 05 data %h", wa.size() ? {wa[0], wd[0]} : 80'h0, {8'hA5, 32'd164, 32'd4});
        end
        checks++;
        if (wc.size() != 1 || ac.size() != 1 || wc[0] - ac[0] != 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 4", (wc.size() && ac.size()) ? wc[0] - ac[0] : -1);
        end
    endtask

    task automatic test_hazard();
        clear();
        upd_addr = 4'd7;
        upd_len = 16'd10;
        upd_valid = 1'b1;
        step();
        upd_len = 16'd20;
        for (int i = 0; i < 30 && ac.size() < 2; i++) step();
        upd_valid = 1'b0;
        repeat (10) step();
        checks++;
        if (ac.size() != 2 || wa.size() != 2) begin
            errors++;
            $display("FAIL hazard_count: got %0d accepts %0d writes expected 2 and 2", ac.size(), wa.size());
        end
        checks++;
        if (ac.size() != 2 || wc.size() == 0 || ac[1] != wc[0] + 1) begin
            errors++;
            $display("FAIL hazard_stall: got second accept %0d expected one after first write %0d",
                     ac.size() > 1 ? ac[1] : -1, wc.size() ? wc[0] : -1);
        end
        checks++;
        if (wd.size() != 2 || wd[0] !== {8'h0, 32'd10, 32'd1}) begin
            errors++;
            $display("FAIL hazard_first: got %h expected %h", wd.size() ? wd[0] : 72'h0, {8'h0, 32'd10, 32'd1});
        end
        checks++;
        if (wd.size() != 2 || wa[1] !== 8'd7 || wd[1] !== {8'h0, 32'd30, 32'd2}) begin
            errors++;
            $display("FAIL hazard_final: got %h expected %h", wd.size() > 1 ? wd[1] : 72'h0, {8'h0, 32'd30, 32'd2});
        end
    endtask

    task automatic test_saturate();
        bit ok;
        preload(4'd9, {8'h3C, 32'hFFFF_FFF0, 32'hFFFF_FFFF});
        clear();
        offer(4'd9, 16'd32, ok);
        repeat (8) step();
        checks++;
        if (!ok || wd.size() != 1 || wd[0] !== {8'h3C, 32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL saturate_clamp: got %h expected %h", wd.size() ? wd[0] : 72'h0, {8'h3C, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        end
        checks++;
        if (wd0.size() != 1 || wd0[0] !== {8'h3C, 32'h10, 32'h0}) begin
            errors++;
            $display("FAIL saturate_wrap: got %h expected %h", wd0.size() ? wd0[0] : 72'h0, {8'h3C, 32'h10, 32'h0});
        end
    endtask

    task automatic test_back_to_back();
        int i = 0;
        int held_acc, held_wr, n;
        clear();
        wr_full = 1'b1;
        for (int c = 0; c < 20; c++) begin
            upd_valid = i < 6;
            upd_addr = 4'(10 + i);
            upd_len = 16'(100 + i);
            n = ac.size();
            step();
            if (ac.size() != n) i++;
        end
        held_acc = i;
        held_wr = wa.size();
        wr_full = 1'b0;
        for (int c = 0; c < 40 && i < 6; c++) begin
            upd_valid = 1'b1;
            upd_addr = 4'(10 + i);
            upd_len = 16'(100 + i);
            n = ac.size();
            step();
            if (ac.size() != n) i++;
        end
        upd_valid = 1'b0;
        repeat (15) step();
        checks++;
        if (held_acc != 4) begin
            errors++;
            $display("FAIL bp_accepts: got %0d expected 4", held_acc);
        end
        checks++;
        if (held_wr != 0) begin
            errors++;
            $display("FAIL bp_no_write: got %0d writes expected 0", held_wr);
        end
        checks++;
        if (wa.size() != 6) begin
            errors++;
            $display("FAIL bp_total: got %0d writes expected 6", wa.size());
        end
        for (int j = 0; j < wa.size(); j++) begin
            checks++;
            if (wa[j] !== 8'(10 + j) || wd[j] !== {8'h0, 32'(100 + j), 32'd1}) begin
                errors++;
                $display("FAIL bp_write%0d: got addr %0d data %h expected addr %0d data %h", j, wa[j], wd[j], 10 + j, {8'h0, 32'(100 + j), 32'd1});
            end
        end
    endtask

    task automatic test_reinit();
        bit ok;
        int bad = 0;
        clear();
        offer(4'd3, 16'd8, ok);
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        done_cyc = -1;
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL reinit_drop: got init_done %b expected 0", init_done);
        end
        for (int i = 0; i < 60 && done_cyc < 0; i++) step();
        checks++;
        if (!ok || wa.size() != 17) begin
            errors++;
            $display("FAIL reinit_count: got %0d writes expected 17", wa.size());
        end
        checks++;
        if (wa.size() == 0 || wa[0] !== 8'd3 || wd[0] !== {8'h0, 32'd8, 32'd1}) begin
            errors++;
            $display("FAIL reinit_drain_write: got %h expected addr 03 data %h", wa.size() ? {wa[0], wd[0]} : 80'h0, {8'h0, 32'd8, 32'd1});
        end
        for (int j = 1; j < wa.size(); j++) if (wa[j] !== 8'(j - 1) || wd[j] !== 72'h0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reinit_zero_fill: got %0d bad writes expected 0", bad);
        end
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL reinit_done: got init_done 0 expected 1");
        end
    endtask

    task automatic test_unexpected();
        int n;
        checks++;
        if (err_unexpected !== 1'b0) begin
            errors++;
            $display("FAIL unexp_before: got %b expected 0", err_unexpected);
        end
        n = wa.size();
        inj = 1'b1;
        step();
        inj = 1'b0;
        repeat (6) step();
        checks++;
        if (err_unexpected !== 1'b1) begin
            errors++;
            $display("FAIL unexp_flag: got %b expected 1", err_unexpected);
        end
        checks++;
        if (wa.size() != n) begin
            errors++;
            $display("FAIL unexp_no_write: got %0d writes expected 0", wa.size() - n);
        end
    endtask

    task automatic test_reset_mid_init();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear();
        repeat (6) step();
        checks++;
        if (wa.size() == 0) begin
            errors++;
            $display("FAIL rmi_started: got 0 writes expected some");
        end
        reset = 1'b1;
        step();
        checks++;
        if ({rd_req, wr_req, init_done, upd_ready, err_unexpected} !== 5'b0 || wr_addr !== 8'h0 || wr_data !== 72'h0) begin
            errors++;
            $display("FAIL rmi_reset_values: got %b %h %h expected 00000 00 0",
                     {rd_req, wr_req, init_done, upd_ready, err_unexpected}, wr_addr, wr_data);
        end
        reset = 1'b0;
        clear();
        for (int i = 0; i < 40 && done_cyc < 0; i++) step();
        checks++;
        if (wa.size() != 16 || wa[0] !== 8'd0 || wa[15] !== 8'd15) begin
            errors++;
            $display("FAIL rmi_restart: got %0d writes first %0d expected 16 starting at 0", wa.size(), wa.size() ? wa[0] : 8'hFF);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_basic();
        test_hazard();
        test_saturate();
        test_back_to_back();
        test_reinit();
        test_unexpected();
        test_reset_mid_init();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
